// File: rtl/word_serializer.sv
// word_serializer: loads a parallel word and shifts it out one bit per
// valid/ready transfer; asynchronous active-low clear, MSB- or LSB-first.
module word_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  ser_data,
  output logic                  ser_last,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  accept;
  logic                  xfer;
  logic                  last;

  assign last   = (cnt_q == '0);
  assign accept = in_valid && in_ready;
  assign xfer   = ser_valid && ser_ready;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = data_in;
          cnt_d   = CW'(DATA_WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            // Move the next bit into the output position.
            shreg_d = MSB_FIRST ?
                      {shreg_q[DATA_WIDTH-2:0], 1'b0} :
                      {1'b0, shreg_q[DATA_WIDTH-1:1]};
            cnt_d   = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready gated by clr so it drops and rises without a clock edge.
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: in_ready = clr;
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_data  = MSB_FIRST ?
                    shreg_q[DATA_WIDTH-1] :
                    shreg_q[0];
        ser_last  = last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed scenarios driving an MSB-first and an
// LSB-first instance in lockstep, checked against per-instance bit queues.
module tb_word_serializer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          ser_ready = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic m_in_ready, m_ser_valid, m_ser_data, m_ser_last, m_busy;
  logic l_in_ready, l_ser_valid, l_ser_data, l_ser_last, l_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] qm[$];
  logic [1:0] ql[$];

  always #5 clk = ~clk;

  word_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(m_in_ready),
    .data_in(data_in),
    .ser_valid(m_ser_valid), .ser_ready(ser_ready),
    .ser_data(m_ser_data), .ser_last(m_ser_last),
    .busy(m_busy)
  );

  word_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(l_in_ready),
    .data_in(data_in),
    .ser_valid(l_ser_valid), .ser_ready(ser_ready),
    .ser_data(l_ser_data), .ser_last(l_ser_last),
    .busy(l_busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) begin
      qm.push_back({w[DW-1-i], 1'b0 ^ (i == DW-1)});
      ql.push_back({w[i], 1'b0 ^ (i == DW-1)});
    end
  endtask

  task automatic check_outs_off(input string tag, input logic rdy);
    chk({tag, "_m_valid"}, m_ser_valid, 1'b0);
    chk({tag, "_l_valid"}, l_ser_valid, 1'b0);
    chk({tag, "_m_data"}, m_ser_data, 1'b0);
    chk({tag, "_l_data"}, l_ser_data, 1'b0);
    chk({tag, "_m_last"}, m_ser_last, 1'b0);
    chk({tag, "_l_last"}, l_ser_last, 1'b0);
    chk({tag, "_m_busy"}, m_busy, 1'b0);
    chk({tag, "_l_busy"}, l_busy, 1'b0);
    chk({tag, "_m_in_ready"}, m_in_ready, rdy);
    chk({tag, "_l_in_ready"}, l_in_ready, rdy);
  endtask

  task automatic check_bit(input string tag, input logic pop);
    logic [1:0] em, el;
    if (qm.size() == 0 || ql.size() == 0) begin
      chk_int({tag, "_queue_empty"}, 0, 1);
      return;
    end
    if (pop) begin
      em = qm.pop_front();
      el = ql.pop_front();
    end else begin
      em = qm[0];
      el = ql[0];
    end
    chk({tag, "_m_valid"}, m_ser_valid, 1'b1);
    chk({tag, "_l_valid"}, l_ser_valid, 1'b1);
    chk({tag, "_m_busy"}, m_busy, 1'b1);
    chk({tag, "_m_in_ready"}, m_in_ready, 1'b0);
    chk({tag, "_l_in_ready"}, l_in_ready, 1'b0);
    chk({tag, "_m_data"}, m_ser_data, em[1]);
    chk({tag, "_m_last"}, m_ser_last, em[0]);
    chk({tag, "_l_data"}, l_ser_data, el[1]);
    chk({tag, "_l_last"}, l_ser_last, el[0]);
  endtask

  // Accept w, stream it out, then leave (nv, nd) on the input side.
  task automatic run_word(input string tag, input logic [DW-1:0] w,
                          input logic toggle, input logic nv,
                          input logic [DW-1:0] nd, input int exp_cyc);
    int cyc;
    int k;
    @(negedge clk);
    check_outs_off({tag, "_idle"}, 1'b1);
    in_valid = 1'b1;
    data_in  = w;
    push_word(w);
    @(posedge clk);
    #1;
    in_valid = nv;
    data_in  = nd;
    cyc = 1;
    k   = 0;
    while (qm.size() > 0 && cyc < 40) begin
      ser_ready = toggle ? (k % 2 == 0) : 1'b1;
      @(negedge clk);
      check_bit(tag, ser_ready);
      @(posedge clk);
      #1;
      cyc++;
      k++;
    end
    ser_ready = 1'b0;
    chk_int({tag, "_cycles"}, cyc, exp_cyc);
    qm.delete();
    ql.delete();
  endtask

  initial begin
    #2;
    check_outs_off("reset", 1'b0);
    #1 clr = 1'b1;
    #1;
    chk("release_m_in_ready", m_in_ready, 1'b1);
    chk("release_l_in_ready", l_in_ready, 1'b1);

    run_word("s1", 8'hA5, 1'b0, 1'b0, 8'h00, DW + 1);
    run_word("s2", 8'hA5, 1'b1, 1'b0, 8'h00, 2 * DW);
    run_word("s3", 8'hA5, 1'b0, 1'b1, 8'hFF, DW + 1);
    run_word("s3ff", 8'hFF, 1'b0, 1'b0, 8'h00, DW + 1);

    // Reset mid-word after three transfers.
    @(negedge clk);
    check_outs_off("s4_idle", 1'b1);
    in_valid = 1'b1;
    data_in  = 8'hA5;
    push_word(8'hA5);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ser_ready = 1'b1;
      @(negedge clk);
      check_bit("s4_pre", 1'b1);
      @(posedge clk);
      #1;
    end
    #2 clr = 1'b0;
    #1;
    check_outs_off("s4_clr", 1'b0);
    qm.delete();
    ql.delete();
    @(posedge clk);
    @(negedge clk);
    check_outs_off("s4_held", 1'b0);
    #2 clr = 1'b1;
    #1;
    chk("s4_rel_m_in_ready", m_in_ready, 1'b1);
    chk("s4_rel_l_in_ready", l_in_ready, 1'b1);
    ser_ready = 1'b0;
    run_word("s4", 8'h3C, 1'b0, 1'b0, 8'h00, DW + 1);

    run_word("s5", 8'h01, 1'b0, 1'b0, 8'h00, DW + 1);

    run_word("s6a", 8'h81, 1'b0, 1'b1, 8'h42, DW + 1);
    run_word("s6b", 8'h42, 1'b0, 1'b0, 8'h00, DW + 1);

    @(negedge clk);
    check_outs_off("final", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: parallel word width (legal values 2 and above).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends the MSB first, 0 sends the LSB first.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port clr, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: data_in holds a word to load.
REQ-006 SHALL have port in_ready, output, 1: block accepts a word this cycle.
REQ-007 SHALL have port data_in, input, DATA_WIDTH: parallel word, sampled only on the accept cycle.
REQ-008 SHALL have port ser_valid, output, 1: ser_data/ser_last are valid.
REQ-009 SHALL have port ser_ready, input, 1: downstream consumes the current bit.
REQ-010 SHALL have port ser_data, output, 1: current serial bit.
REQ-011 SHALL have port ser_last, output, 1: current bit is the final bit of the word.
REQ-012 SHALL have port busy, output, 1: a word is in flight.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and SHIFT, plus a DATA_WIDTH shift register and a clog2(DATA_WIDTH)-bit down-counter cnt.
REQ-014 SHALL drive in_ready = (state==IDLE) && clr; an accept is in_valid && in_ready at a rising edge.
REQ-015 SHALL, on accept, load data_in into the shift register, set cnt = DATA_WIDTH-1, and enter SHIFT.
REQ-016 SHALL, in SHIFT, drive ser_valid=1, busy=1, ser_data = shreg[DATA_WIDTH-1] if MSB_FIRST else shreg[0], and ser_last = (cnt==0).
REQ-017 SHALL, on a transfer (ser_valid && ser_ready at an edge) with cnt!=0, shift the register one position toward the output bit and decrement cnt.
REQ-018 SHALL, on a transfer with cnt==0, return to IDLE, so that ser_valid=0 on the next cycle.
REQ-019 SHALL, while ser_ready=0 in SHIFT, hold ser_data, ser_last, cnt and shreg unchanged (no bit dropped or duplicated).
REQ-020 SHALL ignore in_valid and data_in in SHIFT; a word is never overwritten mid-flight.
REQ-021 SHALL present the first bit on the cycle after accept (latency 1), with at most one word per DATA_WIDTH+1 cycles at full rate.
REQ-022 SHALL drive ser_data=0 and ser_last=0 whenever ser_valid=0.
REQ-023 SHALL not let ser_ready affect in_ready combinationally (no ready-to-ready path).

Reset
REQ-024 SHALL, on clr low at any time, immediately force: state=IDLE, shreg=0, cnt=0, ser_valid=0, ser_data=0, ser_last=0, busy=0, in_ready=0.
REQ-025 SHALL, after clr returns high, assert in_ready=1, with no clock edge required.
REQ-026 SHALL discard a word interrupted by reset mid-operation, emit no partial ser_last, and leave no residual bits on the next word.

Verification
REQ-027 Scenario 1 (DATA_WIDTH=8, MSB_FIRST=1, ser_ready=1): load 0xA5 -> ser_data 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; ser_last only on the 8th bit; in_ready=1 on the following cycle.
REQ-028 Scenario 2 (backpressure): load 0xA5 with ser_ready toggling 1,0,1,0... -> same bit sequence; each bit held through its ready-low cycles; ser_last on the 8th transfer only; 16 cycles total.
REQ-029 Scenario 3 (load during shift): load 0xA5, then hold in_valid=1 with data_in=0xFF during SHIFT -> in_ready=0 throughout; output remains 0xA5; 0xFF is accepted only in the next IDLE cycle.
REQ-030 Scenario 4 (reset mid-word): load 0xA5, pull clr low after 3 transfers -> ser_valid, busy and in_ready drop to 0 without a clock edge; after release, load 0x3C -> 0,0,1,1,1,1,0,0 with no leftover bits.
REQ-031 Scenario 5 (MSB_FIRST=0): load 0x01 -> 1 then seven 0s; ser_last on the 8th bit.
REQ-032 Scenario 6 (back-to-back): in_valid held high with 0x81 then 0x42 -> 1,0,0,0,0,0,0,1 then one idle cycle then 0,1,0,0,0,0,1,0.
